// File: rtl/sqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arb_pkg
// Description : Shared types and the round-robin pick function for the
//               sqrt_mem read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sqrt_arb_pkg;

  // Default requester count; the arbiter carries its own ID width when
  // instantiated with a different N_REQ.
  localparam int ARB_N_REQ = 2;
  localparam int ARB_ID_W  = (ARB_N_REQ > 1) ? $clog2(ARB_N_REQ) : 1;

  // Widest request vector the pick function handles.
  localparam int RR_MAX = 32;

  typedef logic [ARB_ID_W-1:0] req_id_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // First set bit of valid, searching upward from last+1 and wrapping at n.
  // Returns last when nothing is valid; callers only use it when some bit is.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                          input int unsigned       n,
                                          input int unsigned       last);
    int unsigned idx;
    logic        found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = (last + k) % n;
      if (!found && (k <= n) && valid[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage : sqrt_arb_pkg
`default_nettype wire

// File: rtl/sqrt_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arb_id_fifo
// Description : Synchronous FIFO holding requester IDs in memory issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt count.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule : sqrt_arb_id_fifo
`default_nettype wire

// File: rtl/sqrt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_mem_arbiter
// Description : Round-robin arbiter sharing one sqrt_mem read port between
//               N_REQ requesters; returns data in order to the issuing lane.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_mem_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 8,
  parameter int N_REQ  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_addr_valid,
  output logic [N_REQ-1:0]              req_addr_ready,
  input  logic [N_REQ-1:0][W_ADDR-1:0]  req_addr_data,
  output logic [N_REQ-1:0]              req_data_valid,
  input  logic [N_REQ-1:0]              req_data_ready,
  output logic [W_DATA-1:0]             req_data,
  output logic                          mem_addr_valid,
  input  logic                          mem_addr_ready,
  output logic [W_ADDR-1:0]             mem_addr_data,
  input  logic                          mem_data_valid,
  output logic                          mem_data_ready,
  input  logic [W_DATA-1:0]             mem_data,
  output logic                          err
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              err_q, err_d;

  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   head_id;
  logic              slot_free;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign mem_addr_valid = (state_q == ST_ISSUE);
  assign mem_addr_data  = addr_q;
  assign err            = err_q;
  assign req_data       = mem_data;

  // The issue register can take a new address when empty or being drained this cycle.
  always_comb begin
    slot_free = (state_q == ST_IDLE) || mem_addr_ready;
    accept    = slot_free && !fifo_full && (|req_addr_valid);
    winner    = ID_W'(rr_pick(RR_MAX'(req_addr_valid), N_REQ, 32'(last_q)));
  end

  // Next-state: load the winner on accept, fall idle once drained, else hold.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    last_d         = last_q;
    req_addr_ready = '0;
    if (accept) begin
      state_d                = ST_ISSUE;
      addr_d                 = req_addr_data[winner];
      last_d                 = winner;
      req_addr_ready[winner] = 1'b1;
    end else if (slot_free) begin
      state_d = ST_IDLE;
    end
  end

  // Return path: route memory data to the requester at the head of the ID FIFO.
  always_comb begin
    req_data_valid = '0;
    mem_data_ready = 1'b0;
    err_d          = err_q;
    if (!fifo_empty) begin
      req_data_valid[head_id] = mem_data_valid;
      mem_data_ready          = req_data_ready[head_id];
    end else if (mem_data_valid) begin
      err_d = 1'b1;
    end
    pop = mem_data_valid && mem_data_ready;
  end

  // State, issue address, round-robin pointer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  sqrt_arb_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (winner),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule : sqrt_mem_arbiter
`default_nettype wire

// File: tb/tb_sqrt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_mem_arbiter
// Description : Scoreboard bench for sqrt_mem_arbiter with a sqrt_mem model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_mem_arbiter;

  localparam int W_DATA = 16;
  localparam int W_ADDR = 8;
  localparam int N_REQ  = 2;
  localparam int DEPTH  = 4;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [N_REQ-1:0]             req_addr_valid;
  logic [N_REQ-1:0]             req_addr_ready;
  logic [N_REQ-1:0][W_ADDR-1:0] req_addr_data;
  logic [N_REQ-1:0]             req_data_valid;
  logic [N_REQ-1:0]             req_data_ready;
  logic [W_DATA-1:0]            req_data;
  logic                         mem_addr_valid;
  logic                         mem_addr_ready;
  logic [W_ADDR-1:0]            mem_addr_data;
  logic                         mem_data_valid;
  logic                         mem_data_ready;
  logic [W_DATA-1:0]            mem_data;
  logic                         err;

  sqrt_mem_arbiter #(
    .W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_REQ(N_REQ), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr_valid(req_addr_valid), .req_addr_ready(req_addr_ready),
    .req_addr_data(req_addr_data),
    .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
    .req_data(req_data),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
    .mem_addr_data(mem_addr_data),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready),
    .mem_data(mem_data), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // sqrt_mem contents: address tag in the upper byte, sqrt(addr*256) below.
  function automatic logic [W_DATA-1:0] rom(input logic [W_ADDR-1:0] a);
    return {a, 8'(isqrt(int'(a) * 256))};
  endfunction

  // Round-robin from the rule: first valid requester after the last winner.
  function automatic int rr_ref(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  // ---------------- knobs driven by the main sequence ----------------
  int req_mode     = 0;  // 0 none new, 1 fixed 0x10/0x20, 2 random
  int rdyd_mode    = 0;  // 0 all ready, 1 random, 2 none ready
  int mem_rdy_mode = 0;  // 0 ready, 1 random, 2 stalled
  int lat          = 2;
  bit rand_lat     = 0;
  bit resp_hold    = 0;
  bit spurious     = 0;

  // ---------------- requester driver (holds a request until accepted) -------
  logic [N_REQ-1:0] acc_prev = '0;
  initial begin
    req_addr_valid = '0;
    req_addr_data  = '0;
    req_data_ready = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_addr_valid[i] || acc_prev[i]) begin
          case (req_mode)
            1: begin req_addr_valid[i] = 1'b1; req_addr_data[i] = 8'(16 * (i + 1)); end
            2: begin req_addr_valid[i] = 1'($urandom_range(0, 1)); req_addr_data[i] = 8'($urandom); end
            default: req_addr_valid[i] = 1'b0;
          endcase
        end
      end
      case (rdyd_mode)
        0:       req_data_ready = '1;
        1:       req_data_ready = N_REQ'($urandom);
        default: req_data_ready = '0;
      endcase
      #3;
      acc_prev = req_addr_valid & req_addr_ready;
    end
  end

  // ---------------- sqrt_mem model: in-order responses after a latency ------
  int mq_addr[$];
  int mq_due[$];
  int cyc = 0;
  initial begin
    int d;
    mem_addr_ready = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = '0;
    forever begin
      @(negedge clk);
      #1;
      case (mem_rdy_mode)
        0:       mem_addr_ready = 1'b1;
        1:       mem_addr_ready = 1'($urandom_range(0, 1));
        default: mem_addr_ready = 1'b0;
      endcase
      if (spurious) begin
        mem_data_valid = 1'b1;
        mem_data       = 16'hDEAD;
      end else if (!rst && !resp_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        mem_data_valid = 1'b1;
        mem_data       = rom(W_ADDR'(mq_addr[0]));
      end else begin
        mem_data_valid = 1'b0;
        mem_data       = 16'($urandom);
      end
      #2;
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
      end else begin
        if (mem_data_valid && mem_data_ready && !spurious) begin
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (mem_addr_valid && mem_addr_ready) begin
          d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
          if (mq_due.size() > 0 && d < mq_due[mq_due.size() - 1]) d = mq_due[mq_due.size() - 1];
          mq_addr.push_back(int'(mem_addr_data));
          mq_due.push_back(d);
        end
      end
      cyc++;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int   ord_q[$];           // requester IDs in acceptance order
  int   exp_q[N_REQ][$];    // expected data per requester
  int   grant_log[$];       // observed grants, for sequence checks
  int   outst = 0;
  int   last_m = N_REQ - 1;
  bit   err_m = 0;
  bit   prev_acc = 0;
  bit   prev_stall = 0;
  logic [W_ADDR-1:0] prev_addr = '0;
  logic [W_ADDR-1:0] stall_addr = '0;
  int   n_grants = 0;
  int   n_pops = 0;

  task automatic monitor_cycle();
    int  h, w, outst_pre, act_w;
    bit  slot, exp_acc;
    chk("err", 32'(err), 32'(err_m));
    if (prev_acc) begin
      chk("issue_valid", 32'(mem_addr_valid), 1);
      chk("issue_addr", 32'(mem_addr_data), 32'(prev_addr));
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(mem_addr_valid), 1);
      chk("stall_addr", 32'(mem_addr_data), 32'(stall_addr));
    end
    outst_pre = outst;
    // return path
    if (ord_q.size() == 0) begin
      chk("dvalid_empty", 32'(req_data_valid), 0);
      chk("mready_empty", 32'(mem_data_ready), 0);
      if (mem_data_valid) err_m = 1'b1;
    end else begin
      h = ord_q[0];
      chk("dvalid", 32'(req_data_valid), mem_data_valid ? (32'd1 << h) : 32'd0);
      chk("mready", 32'(mem_data_ready), 32'(req_data_ready[h]));
      if (mem_data_valid && req_data_ready[h]) begin
        chk("rdata", 32'(req_data), 32'(exp_q[h].pop_front()));
        void'(ord_q.pop_front());
        outst--;
        n_pops++;
      end
    end
    // address path
    slot    = !mem_addr_valid || mem_addr_ready;
    exp_acc = slot && (outst_pre < DEPTH) && (|req_addr_valid);
    chk("accept", 32'(|req_addr_ready), 32'(exp_acc));
    if (exp_acc) begin
      w = rr_ref(req_addr_valid, last_m);
      chk("grant", 32'(req_addr_ready), 32'd1 << w);
      act_w = -1;
      for (int i = N_REQ - 1; i >= 0; i--) if (req_addr_ready[i]) act_w = i;
      grant_log.push_back(act_w);
      exp_q[w].push_back(int'(rom(req_addr_data[w])));
      ord_q.push_back(w);
      last_m    = w;
      outst++;
      n_grants++;
      prev_addr = req_addr_data[w];
    end
    prev_acc   = exp_acc;
    prev_stall = mem_addr_valid && !mem_addr_ready;
    stall_addr = mem_addr_data;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        ord_q.delete();
        for (int i = 0; i < N_REQ; i++) exp_q[i].delete();
        outst      = 0;
        last_m     = N_REQ - 1;
        err_m      = 1'b0;
        prev_acc   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        monitor_cycle();
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    req_mode = 0;
    while ((outst != 0 || req_addr_valid != '0) && n < max) begin
      cycles(1);
      n++;
    end
    chk("drain_done", 32'(outst == 0 && req_addr_valid == '0), 1);
  endtask

  task automatic wait_grants(input int target, input int max);
    int n = 0;
    while (n_grants < target && n < max) begin
      cycles(1);
      n++;
    end
    chk("grant_wait", 32'(n_grants >= target), 1);
  endtask

  initial begin
    int g, p, n;
    cycles(3);
    rst = 1'b0;

    // reset state
    @(negedge clk); #3;
    chk("rst_mem_addr_valid", 32'(mem_addr_valid), 0);
    chk("rst_mem_addr_data", 32'(mem_addr_data), 0);
    chk("rst_req_addr_ready", 32'(req_addr_ready), 0);
    chk("rst_req_data_valid", 32'(req_data_valid), 0);
    chk("rst_mem_data_ready", 32'(mem_data_ready), 0);
    chk("rst_err", 32'(err), 0);

    // fairness: both requesters always valid, grants alternate from 0
    cycles(1);
    g = n_grants;
    req_mode = 1;
    cycles(20);
    for (int k = 0; k < 8; k++) chk("alternate", 32'(grant_log[g + k]), 32'(k % 2));
    drain(50);

    // address backpressure for 5 cycles after the first accept
    g = n_grants;
    req_mode = 1;
    wait_grants(g + 1, 10);
    mem_rdy_mode = 2;
    g = n_grants;
    cycles(5);
    chk("stall_no_grant", 32'(n_grants - g), 0);
    mem_rdy_mode = 0;
    cycles(1);
    chk("grant_on_ready", 32'(n_grants - g), 1);
    drain(50);

    // FIFO full with no returning data
    resp_hold = 1;
    g = n_grants;
    req_mode = 1;
    cycles(12);
    chk("full_accepts", 32'(n_grants - g), DEPTH);
    resp_hold = 0;
    p = n_pops;
    n = 0;
    while (n_pops == p && n < 20) begin cycles(1); n++; end
    chk("full_pop_seen", 32'(n_pops > p), 1);
    drain(60);

    // data backpressure on the head requester
    resp_hold = 1;
    req_mode = 1;
    cycles(2);
    req_mode = 0;
    cycles(4);
    rdyd_mode = 2;
    resp_hold = 0;
    p = n_pops;
    repeat (3) begin
      @(negedge clk); #3;
      chk("dbp_mem_valid", 32'(mem_data_valid), 1);
      chk("dbp_mem_ready", 32'(mem_data_ready), 0);
      if (ord_q.size() > 0)
        chk("dbp_other_valid", 32'(req_data_valid & ~(N_REQ'(1) << ord_q[0])), 0);
    end
    rdyd_mode = 0;
    chk("dbp_no_pop", 32'(n_pops - p), 0);
    drain(60);

    // randomized traffic
    req_mode = 2; rdyd_mode = 1; mem_rdy_mode = 1; rand_lat = 1;
    cycles(400);
    rdyd_mode = 0; mem_rdy_mode = 0; rand_lat = 0;
    drain(300);

    // spurious memory data -> sticky error
    spurious = 1;
    cycles(1);
    spurious = 0;
    cycles(3);
    chk("err_sticky", 32'(err), 1);

    // reset with reads outstanding
    resp_hold = 1;
    req_mode = 1;
    n = 0;
    while (outst < 2 && n < 20) begin cycles(1); n++; end
    chk("two_outstanding", 32'(outst >= 2), 1);
    rst = 1;
    cycles(1);
    g = n_grants;
    rst = 0;
    resp_hold = 0;
    @(negedge clk); #3;
    chk("post_rst_err", 32'(err), 0);
    chk("post_rst_dvalid", 32'(req_data_valid), 0);
    wait_grants(g + 1, 10);
    chk("post_rst_first_grant", 32'(grant_log[g]), 0);
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a phase wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_sqrt_mem_arbiter
`default_nettype wire
